idex_stage_reg: RTL
===================

# idex_stage_reg

ID/EX pipeline register for the 5-stage RV32I core. It captures decoded instruction, PC, register operands, immediate and control bits from ID each cycle and presents them to the EX stage forwarding unit and ALU. It honours the EX-stage load-use stall by holding its contents, and the branch/jump flush by inserting a bubble. While held, it refreshes operands from the writeback port so a stalled consumer never loses a producer that retires during the stall. Two saturating performance counters report stall and flush activity.

## Interface
Parameters:
- NOP_INSTR, 32'h00000013, instruction word emitted for a bubble (addi x0,x0,0)
- CNT_W, 16, width of the stall/flush counters

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- valid_ID  in  1  ID holds a real instruction
- Instruction_ID  in  32  decoded instruction word (rs1 [19:15], rs2 [24:20], rd [11:7])
- PC_ID  in  32  PC of the ID instruction
- RegData1_ID, RegData2_ID  in  32 each  register file read data
- Imm_ID  in  32  sign-extended immediate
- RegWrite_ID, MemRead_ID, MemWrite_ID, ALUSrc_ID  in  1 each  control bits
- ALUOp_ID  in  4  ALU operation select
- stall_IDEX  in  1  hold request (load_use_hazard from EX)
- flush_IDEX  in  1  kill request (taken branch/jump resolved in EX)
- we_MEMWB  in  1  writeback enable
- rd_MEMWB  in  5  writeback destination
- WB_data  in  32  writeback value
- Instruction_IDEX, PC_IDEX, RegData1_IDEX, RegData2_IDEX, Imm_IDEX  out  32 each  registered copies
- RegWrite_IDEX, MemRead_IDEX, MemWrite_IDEX, ALUSrc_IDEX, valid_IDEX  out  1 each
- ALUOp_IDEX  out  4
- stall_ID  out  1  combinational = stall_IDEX & ~flush_IDEX; tells IF/ID to hold
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

## Operation
- Per-edge priority: rst > flush_IDEX > stall_IDEX > load.
- rst: Instruction_IDEX=NOP_INSTR; PC, RegData1/2, Imm = 0; all control bits, valid_IDEX, ALUOp = 0; both counters = 0.
- flush (regardless of stall): load bubble — same values as reset except counters; flush_cnt += 1 (saturate at all-ones). Stall is not counted that cycle.
- stall (no flush): all fields held, except operand refresh: if we_MEMWB && rd_MEMWB!=0 && rd_MEMWB==Instruction_IDEX[19:15] then RegData1_IDEX<=WB_data; same independently for [24:20] → RegData2_IDEX. stall_cnt += 1 (saturate).
- load: all fields from ID. Capture bypass: if we_MEMWB && rd_MEMWB!=0 && rd_MEMWB==Instruction_ID[19:15], RegData1_IDEX<=WB_data instead of RegData1_ID (register-file write-through); same for rs2.
- valid_ID=0 on load: capture as bubble (NOP_INSTR, controls 0, valid_IDEX 0), operands 0.
- Bubbles never assert RegWrite/MemRead/MemWrite, so downstream forwarding and load-use detection see no producer.
- Refresh/bypass uses rd≠0; x0 never overwritten by WB_data.
- Counters stick at 2^CNT_W−1; no wrap.

## Timing
- Latency: 1 cycle ID→EX for every field.
- stall_ID is purely combinational from stall_IDEX/flush_IDEX, same cycle.
- Stall of N cycles holds the instruction N edges; it is presented to EX for N+1 cycles total.
- Simultaneous stall+flush: flush wins, bubble loaded, stall_ID=0, only flush_cnt increments.
- Refresh and stall on same edge: refreshed operand visible the cycle after that edge.
- rst asserted mid-stall or mid-flush: reset values next edge; counters cleared.
- No combinational path from ID inputs to IDEX outputs.

## Test plan
- Reset: assert rst 2 cycles with random inputs → Instruction_IDEX=0x00000013, all controls/valid 0, counters 0.
- Pass-through: ID add x3,x1,x2 (0x002081B3), PC 0x100, RegData1=5, RegData2=7 → next cycle same values out, RegWrite_IDEX=1, valid_IDEX=1.
- Stall + refresh: hold sub x5,x4,x6 for 2 cycles (stall_IDEX=1); cycle 1 WB writes x4=0xDEAD → RegData1_IDEX=0xDEAD from cycle 2, RegData2 unchanged, stall_cnt=2.
- Capture bypass: ID reads x7 (stale 0x1) while WB writes x7=0x42 → RegData2_IDEX=0x42; with rd_MEMWB=0 and WB_data=0x42 → stale value kept.
- Flush priority: stall_IDEX=1 and flush_IDEX=1 same cycle with lw in ID → bubble out, MemRead_IDEX=0, stall_ID=0, flush_cnt=1, stall_cnt unchanged.
- Saturation: CNT_W=4, stall 20 cycles → stall_cnt=15 and holds; then rst → 0.

Source files
------------

// File: rtl/idex_stage_reg_if.sv
// ID/EX boundary bundle: ID-side capture inputs, hazard/writeback controls,
// and the registered EX-side outputs plus stall/flush counters.
interface idex_stage_reg_if #(
  parameter int CNT_W = 16
);
  logic             valid_ID;
  logic [31:0]      Instruction_ID;
  logic [31:0]      PC_ID;
  logic [31:0]      RegData1_ID;
  logic [31:0]      RegData2_ID;
  logic [31:0]      Imm_ID;
  logic             RegWrite_ID;
  logic             MemRead_ID;
  logic             MemWrite_ID;
  logic             ALUSrc_ID;
  logic [3:0]       ALUOp_ID;
  logic             stall_IDEX;
  logic             flush_IDEX;
  logic             we_MEMWB;
  logic [4:0]       rd_MEMWB;
  logic [31:0]      WB_data;
  logic [31:0]      Instruction_IDEX;
  logic [31:0]      PC_IDEX;
  logic [31:0]      RegData1_IDEX;
  logic [31:0]      RegData2_IDEX;
  logic [31:0]      Imm_IDEX;
  logic             RegWrite_IDEX;
  logic             MemRead_IDEX;
  logic             MemWrite_IDEX;
  logic             ALUSrc_IDEX;
  logic             valid_IDEX;
  logic [3:0]       ALUOp_IDEX;
  logic             stall_ID;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output valid_ID, Instruction_ID, PC_ID, RegData1_ID, RegData2_ID, Imm_ID,
           RegWrite_ID, MemRead_ID, MemWrite_ID, ALUSrc_ID, ALUOp_ID,
           stall_IDEX, flush_IDEX, we_MEMWB, rd_MEMWB, WB_data,
    input  Instruction_IDEX, PC_IDEX, RegData1_IDEX, RegData2_IDEX, Imm_IDEX,
           RegWrite_IDEX, MemRead_IDEX, MemWrite_IDEX, ALUSrc_IDEX, valid_IDEX,
           ALUOp_IDEX, stall_ID, stall_cnt, flush_cnt
  );

  modport slave (
    input  valid_ID, Instruction_ID, PC_ID, RegData1_ID, RegData2_ID, Imm_ID,
           RegWrite_ID, MemRead_ID, MemWrite_ID, ALUSrc_ID, ALUOp_ID,
           stall_IDEX, flush_IDEX, we_MEMWB, rd_MEMWB, WB_data,
    output Instruction_IDEX, PC_IDEX, RegData1_IDEX, RegData2_IDEX, Imm_IDEX,
           RegWrite_IDEX, MemRead_IDEX, MemWrite_IDEX, ALUSrc_IDEX, valid_IDEX,
           ALUOp_IDEX, stall_ID, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/idex_stage_reg.sv
// ID/EX pipeline register: load/hold/bubble with writeback operand refresh
// during stalls, write-through bypass on capture, and saturating event counters.
module idex_stage_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013,
  parameter int          CNT_W     = 16
) (
  input logic            clk,
  input logic            rst,
  idex_stage_reg_if.slave bus
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      rd1_q, rd1_d;
  logic [31:0]      rd2_q, rd2_d;
  logic [31:0]      imm_q, imm_d;
  logic             regwrite_q, regwrite_d;
  logic             memread_q, memread_d;
  logic             memwrite_q, memwrite_d;
  logic             alusrc_q, alusrc_d;
  logic             valid_q, valid_d;
  logic [3:0]       aluop_q, aluop_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic wb_live;
  logic hold_hit1, hold_hit2, cap_hit1, cap_hit2;
  logic bubble;

  // x0 is hardwired, so a writeback to it must never reach an operand
  assign wb_live   = bus.we_MEMWB && (bus.rd_MEMWB != 5'd0);
  assign hold_hit1 = wb_live && (bus.rd_MEMWB == instr_q[19:15]);
  assign hold_hit2 = wb_live && (bus.rd_MEMWB == instr_q[24:20]);
  assign cap_hit1  = wb_live && (bus.rd_MEMWB == bus.Instruction_ID[19:15]);
  assign cap_hit2  = wb_live && (bus.rd_MEMWB == bus.Instruction_ID[24:20]);
  assign bubble    = bus.flush_IDEX || (!bus.stall_IDEX && !bus.valid_ID);

  assign bus.stall_ID = bus.stall_IDEX & ~bus.flush_IDEX;

  always_comb begin
    instr_d     = instr_q;
    pc_d        = pc_q;
    rd1_d       = rd1_q;
    rd2_d       = rd2_q;
    imm_d       = imm_q;
    regwrite_d  = regwrite_q;
    memread_d   = memread_q;
    memwrite_d  = memwrite_q;
    alusrc_d    = alusrc_q;
    valid_d     = valid_q;
    aluop_d     = aluop_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (bubble) begin
      instr_d    = NOP_INSTR;
      pc_d       = '0;
      rd1_d      = '0;
      rd2_d      = '0;
      imm_d      = '0;
      regwrite_d = 1'b0;
      memread_d  = 1'b0;
      memwrite_d = 1'b0;
      alusrc_d   = 1'b0;
      valid_d    = 1'b0;
      aluop_d    = '0;
    end else if (bus.stall_IDEX) begin
      if (hold_hit1) rd1_d = bus.WB_data;
      if (hold_hit2) rd2_d = bus.WB_data;
    end else begin
      instr_d    = bus.Instruction_ID;
      pc_d       = bus.PC_ID;
      rd1_d      = cap_hit1 ? bus.WB_data : bus.RegData1_ID;
      rd2_d      = cap_hit2 ? bus.WB_data : bus.RegData2_ID;
      imm_d      = bus.Imm_ID;
      regwrite_d = bus.RegWrite_ID;
      memread_d  = bus.MemRead_ID;
      memwrite_d = bus.MemWrite_ID;
      alusrc_d   = bus.ALUSrc_ID;
      valid_d    = 1'b1;
      aluop_d    = bus.ALUOp_ID;
    end

    // a flushed stall is not a stall: only one counter moves per edge
    if (bus.flush_IDEX)      flush_cnt_d = sat_inc(flush_cnt_q);
    else if (bus.stall_IDEX) stall_cnt_d = sat_inc(stall_cnt_q);
  end

  // ID -> EX boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q     <= NOP_INSTR;
      pc_q        <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      imm_q       <= '0;
      regwrite_q  <= 1'b0;
      memread_q   <= 1'b0;
      memwrite_q  <= 1'b0;
      alusrc_q    <= 1'b0;
      valid_q     <= 1'b0;
      aluop_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      imm_q       <= imm_d;
      regwrite_q  <= regwrite_d;
      memread_q   <= memread_d;
      memwrite_q  <= memwrite_d;
      alusrc_q    <= alusrc_d;
      valid_q     <= valid_d;
      aluop_q     <= aluop_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.Instruction_IDEX = instr_q;
  assign bus.PC_IDEX          = pc_q;
  assign bus.RegData1_IDEX    = rd1_q;
  assign bus.RegData2_IDEX    = rd2_q;
  assign bus.Imm_IDEX         = imm_q;
  assign bus.RegWrite_IDEX    = regwrite_q;
  assign bus.MemRead_IDEX     = memread_q;
  assign bus.MemWrite_IDEX    = memwrite_q;
  assign bus.ALUSrc_IDEX      = alusrc_q;
  assign bus.valid_IDEX       = valid_q;
  assign bus.ALUOp_IDEX       = aluop_q;
  assign bus.stall_cnt        = stall_cnt_q;
  assign bus.flush_cnt        = flush_cnt_q;

endmodule
